// File: rtl/fpu_ss_pkg.sv
// Shared types for the FPU subsystem dependency scoreboard.
package fpu_ss_pkg;

  // Writeback channel numbering
  localparam int unsigned WB_FPU = 0;
  localparam int unsigned WB_LSU = 1;

  // Width of the core / rd fields stored per ID entry (supports up to 256 of each)
  localparam int unsigned FIELD_W = 8;

  typedef enum logic [1:0] {
    ID_FREE      = 2'd0,
    ID_PENDING   = 2'd1,
    ID_COMMITTED = 2'd2
  } id_state_e;

  typedef struct packed {
    id_state_e            state;
    logic [FIELD_W-1:0]   core;
    logic [FIELD_W-1:0]   rd;
    logic                 fp;
  } id_entry_t;

endpackage

// File: rtl/fpu_ss_pending_cnt.sv
// One saturating pending-write counter: +1 on inc, -1 per dec bit, -1 on kill.
module fpu_ss_pending_cnt #(
  parameter int unsigned CNT_WIDTH = 2,
  parameter int unsigned NB_WB     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 inc_i,
  input  logic [NB_WB-1:0]     dec_i,
  input  logic                 kill_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);

  localparam int unsigned SUM_W = CNT_WIDTH + $clog2(NB_WB + 2) + 1;
  localparam logic [SUM_W-1:0] MAX_S = SUM_W'({CNT_WIDTH{1'b1}});

  logic [CNT_WIDTH-1:0] cnt_r;
  logic [CNT_WIDTH-1:0] cnt_next_s;
  logic [SUM_W-1:0]     up_s;
  logic [SUM_W-1:0]     down_s;

  // Net change of the cycle, clamped so the counter neither wraps nor underflows
  always_comb begin
    up_s   = SUM_W'(cnt_r) + SUM_W'(inc_i);
    down_s = SUM_W'(kill_i);
    for (int j = 0; j < NB_WB; j++) begin
      down_s = down_s + SUM_W'(dec_i[j]);
    end
    if (down_s > up_s) begin
      cnt_next_s = '0;
    end else if ((up_s - down_s) > MAX_S) begin
      cnt_next_s = '1;
    end else begin
      cnt_next_s = CNT_WIDTH'(up_s - down_s);
    end
  end

  // Counter register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

  assign cnt_o = cnt_r;

endmodule

// File: rtl/fpu_ss_scoreboard.sv
// Multi-core FP register dependency tracker with per-ID commit state and
// multi-channel writeback clearing plus same-cycle forwarding.
module fpu_ss_scoreboard
  import fpu_ss_pkg::*;
#(
  parameter int unsigned NB_CORES   = 8,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned CNT_WIDTH  = 2,
  parameter int unsigned NB_WB      = 2,
  parameter int unsigned FORWARDING = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              alloc_valid_i,
  output logic                              alloc_ready_o,
  input  logic [ID_WIDTH-1:0]               alloc_id_i,
  input  logic [$clog2(NB_CORES)-1:0]       alloc_core_i,
  input  logic [$clog2(NUM_REGS)-1:0]       alloc_rd_i,
  input  logic                              alloc_rd_fp_i,
  input  logic                              commit_valid_i,
  input  logic [ID_WIDTH-1:0]               commit_id_i,
  input  logic                              commit_kill_i,
  input  logic [NB_WB-1:0]                  wb_valid_i,
  input  logic [NB_WB*ID_WIDTH-1:0]         wb_id_i,
  input  logic [$clog2(NB_CORES)-1:0]       query_core_i,
  input  logic [3*$clog2(NUM_REGS)-1:0]     query_rs_i,
  input  logic [2:0]                        query_rs_used_i,
  output logic [2:0]                        dep_rs_o,
  output logic [2:0][NB_WB-1:0]             fwd_o,
  output logic [2**ID_WIDTH-1:0]            id_committed_o,
  output logic                              error_o
);

  localparam int unsigned NB_IDS = 2 ** ID_WIDTH;
  localparam int unsigned CORE_W = $clog2(NB_CORES);
  localparam int unsigned REG_W  = $clog2(NUM_REGS);
  localparam int unsigned CMP_W  = CNT_WIDTH + $clog2(NB_WB + 1) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  id_entry_t            tbl_r [NB_IDS];
  logic                 error_r;
  logic [CNT_WIDTH-1:0] cnt_s [NB_CORES][NUM_REGS];

  logic [ID_WIDTH-1:0]  wb_id_s  [NB_WB];
  id_entry_t            wb_ent_s [NB_WB];
  logic [NB_WB-1:0]     wb_ok_s;
  logic [NB_WB-1:0]     wb_hit_s;
  logic                 wb_err_s;
  id_entry_t            cmt_ent_s;
  logic                 commit_ok_s;
  logic                 kill_dec_s;
  logic                 alloc_go_s;
  logic                 err_s;

  // Writeback decode: legal only on a COMMITTED entry not claimed by another channel
  always_comb begin
    logic dup;
    dup      = 1'b0;
    wb_ok_s  = '0;
    wb_hit_s = '0;
    wb_err_s = 1'b0;
    for (int j = 0; j < NB_WB; j++) begin
      wb_id_s[j]  = wb_id_i[j*ID_WIDTH +: ID_WIDTH];
      wb_ent_s[j] = tbl_r[wb_id_s[j]];
    end
    for (int j = 0; j < NB_WB; j++) begin
      dup = 1'b0;
      for (int k = 0; k < NB_WB; k++) begin
        dup = dup | ((k != j) && wb_valid_i[k] && (wb_id_s[k] == wb_id_s[j]));
      end
      wb_ok_s[j]  = wb_valid_i[j] && (wb_ent_s[j].state == ID_COMMITTED) && !dup;
      wb_hit_s[j] = wb_ok_s[j] && wb_ent_s[j].fp;
      wb_err_s    = wb_err_s | (wb_valid_i[j] & ~wb_ok_s[j]);
    end
  end

  // Commit/kill and allocation acceptance, plus protocol-violation detection
  always_comb begin
    cmt_ent_s     = tbl_r[commit_id_i];
    commit_ok_s   = commit_valid_i && (cmt_ent_s.state == ID_PENDING);
    kill_dec_s    = commit_ok_s && commit_kill_i && cmt_ent_s.fp;
    alloc_ready_o = (tbl_r[alloc_id_i].state == ID_FREE) &&
                    (!alloc_rd_fp_i || (cnt_s[alloc_core_i][alloc_rd_i] != CNT_MAX));
    alloc_go_s    = alloc_valid_i && alloc_ready_o;
    err_s         = wb_err_s || (commit_valid_i && !commit_ok_s) ||
                    (alloc_valid_i && !alloc_ready_o);
  end

  // ID table state machine and sticky error flag; illegal events leave state untouched
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NB_IDS; k++) begin
        tbl_r[k] <= '{state: ID_FREE, core: '0, rd: '0, fp: 1'b0};
      end
      error_r <= 1'b0;
    end else begin
      for (int j = 0; j < NB_WB; j++) begin
        if (wb_ok_s[j]) tbl_r[wb_id_s[j]].state <= ID_FREE;
      end
      if (commit_ok_s) begin
        tbl_r[commit_id_i].state <= commit_kill_i ? ID_FREE : ID_COMMITTED;
      end
      if (alloc_go_s) begin
        tbl_r[alloc_id_i] <= '{state: ID_PENDING,
                               core:  FIELD_W'(alloc_core_i),
                               rd:    FIELD_W'(alloc_rd_i),
                               fp:    alloc_rd_fp_i};
      end
      if (err_s) error_r <= 1'b1;
    end
  end

  // One pending-write counter per core and register
  for (genvar c = 0; c < NB_CORES; c++) begin : g_core
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
      logic             inc_s;
      logic [NB_WB-1:0] dec_s;
      logic             kill_s;

      assign inc_s  = alloc_go_s && alloc_rd_fp_i &&
                      (alloc_core_i == CORE_W'(c)) && (alloc_rd_i == REG_W'(r));
      assign kill_s = kill_dec_s && (cmt_ent_s.core == FIELD_W'(c)) &&
                      (cmt_ent_s.rd == FIELD_W'(r));
      for (genvar j = 0; j < NB_WB; j++) begin : g_dec
        assign dec_s[j] = wb_hit_s[j] && (wb_ent_s[j].core == FIELD_W'(c)) &&
                          (wb_ent_s[j].rd == FIELD_W'(r));
      end

      fpu_ss_pending_cnt #(
        .CNT_WIDTH (CNT_WIDTH),
        .NB_WB     (NB_WB)
      ) u_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (inc_s),
        .dec_i  (dec_s),
        .kill_i (kill_s),
        .cnt_o  (cnt_s[c][r])
      );
    end
  end

  // Source hazard check: forward only when exactly one channel retires the last write
  always_comb begin
    logic [REG_W-1:0]     rs;
    logic [CNT_WIDTH-1:0] cur;
    logic [NB_WB-1:0]     hit;
    logic [CMP_W-1:0]     nhit;
    rs       = '0;
    cur      = '0;
    hit      = '0;
    nhit     = '0;
    dep_rs_o = '0;
    fwd_o    = '0;
    for (int i = 0; i < 3; i++) begin
      rs   = query_rs_i[i*REG_W +: REG_W];
      cur  = cnt_s[query_core_i][rs];
      nhit = '0;
      for (int j = 0; j < NB_WB; j++) begin
        hit[j] = wb_hit_s[j] && (wb_ent_s[j].core == FIELD_W'(query_core_i)) &&
                 (wb_ent_s[j].rd == FIELD_W'(rs));
        nhit   = nhit + CMP_W'(hit[j]);
      end
      dep_rs_o[i] = query_rs_used_i[i] && (CMP_W'(cur) > nhit);
      fwd_o[i]    = ((FORWARDING != 0) && query_rs_used_i[i] &&
                     (CMP_W'(cur) == nhit) && (nhit == CMP_W'(1))) ? hit : '0;
    end
  end

  // Committed-entry status vector
  always_comb begin
    id_committed_o = '0;
    for (int k = 0; k < NB_IDS; k++) begin
      id_committed_o[k] = (tbl_r[k].state == ID_COMMITTED);
    end
  end

  assign error_o = error_r;

endmodule
